// File: rtl/sound_arty_x.sv
// sound_arty_x -- Arty A7 tone player.
//
// Walks a fixed C4..C5 scale, one note every NOTE_CYCLES clocks. Each note
// is a triangle wave taken from a phase accumulator. The triangle is sent out
// as PWM_BITS-bit PWM on the mono audio pin.
//
// Ports
//   CLK100MHZ  in   100 MHz board clock; all logic runs on its rising edge
//   BTNC       in   synchronous active-low reset
//   SW[0]      in   audio enable (async): 1 = play, 0 = mute and pause
//   AUD_PWM    out  registered PWM audio, push-pull logic level
module sound_arty_x #(
  parameter int PWM_BITS    = 8,
  parameter int PHASE_BITS  = 24,
  parameter int NOTE_CYCLES = 25_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       BTNC,
  input  logic [0:0] SW,
  output logic       AUD_PWM
);

  localparam int DUR_W = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_CYCLES - 1);

  logic                  r_sync0;
  logic                  r_en;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [PWM_BITS-1:0]   r_duty;
  logic [PHASE_BITS-1:0] r_phase;
  logic [2:0]            r_note;
  logic [DUR_W-1:0]      r_dur;

  logic [PHASE_BITS-1:0] w_inc;
  logic [PWM_BITS-1:0]   w_t;
  logic [PWM_BITS-1:0]   w_sample;
  logic                  w_note_end;
  logic                  w_frame_end;

  // Phase increments per note: INC = f * 2^24 / 100 MHz, rounded.
  always_comb begin
    w_inc = '0;
    case (r_note)
      3'd0: w_inc = PHASE_BITS'(44);  // C4
      3'd1: w_inc = PHASE_BITS'(49);  // D4
      3'd2: w_inc = PHASE_BITS'(55);  // E4
      3'd3: w_inc = PHASE_BITS'(59);  // F4
      3'd4: w_inc = PHASE_BITS'(66);  // G4
      3'd5: w_inc = PHASE_BITS'(74);  // A4
      3'd6: w_inc = PHASE_BITS'(83);  // B4
      3'd7: w_inc = PHASE_BITS'(88);  // C5
    endcase
  end

  // The MSB picks the rising or falling half of the triangle. The bits
  // below it give the position within that half.
  assign w_t         = r_phase[PHASE_BITS-2 -: PWM_BITS];
  assign w_sample    = r_phase[PHASE_BITS-1] ? ~w_t : w_t;
  assign w_note_end  = (r_dur == DUR_LAST);
  assign w_frame_end = &r_pwm_cnt;

  always_ff @(posedge CLK100MHZ) begin
    if (!BTNC) begin
      r_sync0   <= 1'b0;
      r_en      <= 1'b0;
      r_pwm_cnt <= '0;
      r_duty    <= '0;
      r_phase   <= '0;
      r_note    <= '0;
      r_dur     <= '0;
      AUD_PWM   <= 1'b0;
    end else begin
      // Two-flop synchronizer for the enable switch.
      r_sync0   <= SW[0];
      r_en      <= r_sync0;
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      // Duty is latched only at the frame boundary, so each frame is clean.
      // It keeps tracking while muted; the output gate hides it.
      if (w_frame_end)
        r_duty <= w_sample;
      AUD_PWM <= r_en & (r_pwm_cnt < r_duty);
      // Muting freezes phase and note position, so unmute resumes mid-note.
      if (r_en) begin
        r_phase <= r_phase + w_inc;
        if (w_note_end) begin
          r_dur  <= '0;
          r_note <= r_note + 3'd1;
        end else begin
          r_dur <= r_dur + DUR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sound_arty_x.sv
// Bench for sound_arty_x, built with NOTE_CYCLES=1000.
// The reference model counts enabled clocks since reset. Phase, note and
// duration are then derived from that count in closed form.
module tb_sound_arty_x;

  localparam int NC = 1000;

  logic       clk;
  logic       btnc;
  logic [0:0] sw;
  logic       aud;

  int checks = 0;
  int errors = 0;

  int INC_TAB [0:7] = '{44, 49, 55, 59, 66, 74, 83, 88};

  sound_arty_x #(.PWM_BITS(8), .PHASE_BITS(24), .NOTE_CYCLES(NC)) dut (
    .CLK100MHZ(clk),
    .BTNC     (btnc),
    .SW       (sw),
    .AUD_PWM  (aud)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase after e enabled clocks: the sum of increments over whole notes,
  // plus the partial note, taken mod 2^24.
  function automatic longint phase_of(input int e);
    longint acc;
    int full;
    acc  = 0;
    full = e / NC;
    for (int k = 0; k < full; k++) acc += longint'(NC) * INC_TAB[k % 8];
    acc += longint'(e % NC) * INC_TAB[full % 8];
    return acc % (longint'(1) << 24);
  endfunction

  function automatic int note_of(input int e);
    return (e / NC) % 8;
  endfunction

  function automatic int tri8(input longint p);
    int t;
    t = int'((p >> 15) & 255);
    return ((p >> 23) & 1) != 0 ? 255 - t : t;
  endfunction

  // Reference state: enable arrives two clocks after SW. m_e counts enabled
  // clocks. m_cnt is the frame position. m_duty is the duty latched at the
  // last frame end.
  logic m_s1 = 1'b0, m_en = 1'b0;
  int   m_e = 0, m_cnt = 0, m_duty = 0;

  always @(posedge clk) begin
    if (!btnc) begin
      m_s1 <= 1'b0; m_en <= 1'b0; m_e <= 0; m_cnt <= 0; m_duty <= 0;
    end else begin
      m_s1  <= sw[0];
      m_en  <= m_s1;
      if (m_en) m_e <= m_e + 1;
      m_cnt <= (m_cnt + 1) % 256;
      if (m_cnt == 255) m_duty <= tri8(phase_of(m_e));
    end
  end

  task automatic test_reset;
    btnc = 1'b1; sw = 1'b0;
    repeat (2) @(negedge clk);
    btnc = 1'b0;
    @(negedge clk);
    checks++; if (aud !== 1'b0) begin errors++; $display("FAIL rst_aud got %0d want 0", aud); end
    checks++; if (dut.r_phase !== 24'd0) begin errors++; $display("FAIL rst_phase got %0d want 0", dut.r_phase); end
    checks++; if (dut.r_note !== 3'd0) begin errors++; $display("FAIL rst_note got %0d want 0", dut.r_note); end
    checks++; if (dut.r_dur !== '0) begin errors++; $display("FAIL rst_dur got %0d want 0", dut.r_dur); end
    checks++; if (dut.r_pwm_cnt !== 8'd0) begin errors++; $display("FAIL rst_pwm_cnt got %0d want 0", dut.r_pwm_cnt); end
    checks++; if (dut.r_duty !== 8'd0) begin errors++; $display("FAIL rst_duty got %0d want 0", dut.r_duty); end
    checks++; if ({dut.r_sync0, dut.r_en} !== 2'b00) begin errors++; $display("FAIL rst_sync got %0b want 00", {dut.r_sync0, dut.r_en}); end
    @(negedge clk);
    checks++; if (aud !== 1'b0) begin errors++; $display("FAIL rst_aud2 got %0d want 0", aud); end
    btnc = 1'b1;
    @(negedge clk);
    checks++; if (aud !== 1'b0) begin errors++; $display("FAIL rst_aud3 got %0d want 0", aud); end
    checks++; if (dut.r_pwm_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rst_cnt_run got %0d want %0d", dut.r_pwm_cnt, m_cnt); end
  endtask

  task automatic test_muted;
    int bad;
    bad = 0;
    sw = 1'b0;
    repeat (10000) begin
      @(negedge clk);
      checks++;
      if (aud !== 1'b0) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL muted_aud got %0d want 0", aud);
      end
    end
    checks++; if (dut.r_phase !== 24'(phase_of(m_e))) begin errors++; $display("FAIL muted_phase got %0d want %0d", dut.r_phase, phase_of(m_e)); end
    checks++; if (dut.r_note !== 3'd0) begin errors++; $display("FAIL muted_note got %0d want 0", dut.r_note); end
    checks++; if (dut.r_dur !== '0) begin errors++; $display("FAIL muted_dur got %0d want 0", dut.r_dur); end
  endtask

  task automatic test_enable_waveform;
    int n, bad, hi, exp_d;
    sw = 1'b1; n = 0; bad = 0;
    // The output stays low until the triangle sample leaves 0 (phase >= 2^15).
    while (m_e < 746 && n < 2000) begin
      @(negedge clk); n++;
      checks++;
      if (aud !== 1'b0) begin errors++; bad++; if (bad < 5) $display("FAIL early_aud got %0d want 0 at e=%0d", aud, m_e); end
      if (m_e == 744 || m_e == 745) begin
        checks++;
        if (dut.r_phase !== 24'(phase_of(m_e))) begin errors++; $display("FAIL early_phase got %0d want %0d", dut.r_phase, phase_of(m_e)); end
      end
    end
    checks++; if (n >= 2000) begin errors++; $display("FAIL early_timeout got %0d want <2000", n); end
    // Whole-frame high counts must equal the duty latched at the frame start.
    repeat (10) begin
      n = 0;
      do begin @(negedge clk); n++; end while (m_cnt != 0 && n < 300);
      exp_d = m_duty; hi = 0;
      repeat (256) begin @(negedge clk); if (aud === 1'b1) hi++; end
      checks++; if (hi !== exp_d) begin errors++; $display("FAIL frame_high got %0d want %0d", hi, exp_d); end
      checks++; if (hi > 255) begin errors++; $display("FAIL frame_max got %0d want <=255", hi); end
      checks++; if (dut.r_phase !== 24'(phase_of(m_e))) begin errors++; $display("FAIL frame_phase got %0d want %0d", dut.r_phase, phase_of(m_e)); end
    end
  endtask

  task automatic test_sequence;
    int n, e0;
    logic [23:0] p0, p1, dp;
    n = 0;
    while (m_e <= 16001 && n < 16000) begin
      @(negedge clk); n++;
      if (m_e % NC == 0) begin
        e0 = m_e;
        checks++; if (dut.r_note !== 3'(note_of(e0))) begin errors++; $display("FAIL seq_note got %0d want %0d at e=%0d", dut.r_note, note_of(e0), e0); end
        checks++; if (dut.r_dur !== '0) begin errors++; $display("FAIL seq_dur got %0d want 0", dut.r_dur); end
        checks++; if (dut.r_phase !== 24'(phase_of(e0))) begin errors++; $display("FAIL seq_phase got %0d want %0d", dut.r_phase, phase_of(e0)); end
        p0 = dut.r_phase;
        @(negedge clk); n++;
        p1 = dut.r_phase;
        dp = p1 - p0;
        checks++; if (dp !== 24'(INC_TAB[note_of(e0)])) begin errors++; $display("FAIL seq_inc got %0d want %0d at e=%0d", dp, INC_TAB[note_of(e0)], e0); end
      end
    end
    checks++; if (m_e <= 16001) begin errors++; $display("FAIL seq_timeout got e=%0d want >16001", m_e); end
  endtask

  task automatic test_pause_resume;
    int n, bad;
    n = 0; bad = 0;
    while (!(m_e % NC == 500 && note_of(m_e) == 2) && n < 12000) begin @(negedge clk); n++; end
    checks++; if (n >= 12000) begin errors++; $display("FAIL pause_timeout got %0d want <12000", n); end
    checks++; if (dut.r_dur !== 10'd500) begin errors++; $display("FAIL pause_dur0 got %0d want 500", dut.r_dur); end
    sw = 1'b0;
    repeat (3) @(negedge clk);
    repeat (2997) begin
      @(negedge clk);
      checks++;
      if (aud !== 1'b0) begin errors++; bad++; if (bad < 5) $display("FAIL pause_aud got %0d want 0", aud); end
    end
    // Two enabled clocks pass while the synchronizer catches up.
    checks++; if (dut.r_dur !== 10'd502) begin errors++; $display("FAIL pause_dur got %0d want 502", dut.r_dur); end
    checks++; if (dut.r_note !== 3'd2) begin errors++; $display("FAIL pause_note got %0d want 2", dut.r_note); end
    checks++; if (dut.r_phase !== 24'(phase_of(m_e))) begin errors++; $display("FAIL pause_phase got %0d want %0d", dut.r_phase, phase_of(m_e)); end
    sw = 1'b1; n = 0;
    while (dut.r_note == 3'd2 && n < 2000) begin @(negedge clk); n++; end
    // 2 synchronizer clocks plus the remaining 1000-502 clocks of the note.
    checks++; if (n !== 500) begin errors++; $display("FAIL resume_latency got %0d want 500", n); end
    checks++; if (dut.r_note !== 3'd3) begin errors++; $display("FAIL resume_note got %0d want 3", dut.r_note); end
    checks++; if (dut.r_dur !== '0) begin errors++; $display("FAIL resume_dur got %0d want 0", dut.r_dur); end
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    while (!(note_of(m_e) == 5 && m_e % NC == 100) && n < 12000) begin @(negedge clk); n++; end
    checks++; if (n >= 12000) begin errors++; $display("FAIL mid_timeout got %0d want <12000", n); end
    btnc = 1'b0;
    @(negedge clk);
    checks++; if (aud !== 1'b0) begin errors++; $display("FAIL mid_aud got %0d want 0", aud); end
    checks++; if (dut.r_note !== 3'd0) begin errors++; $display("FAIL mid_note got %0d want 0", dut.r_note); end
    checks++; if (dut.r_phase !== 24'd0) begin errors++; $display("FAIL mid_phase got %0d want 0", dut.r_phase); end
    checks++; if (dut.r_dur !== '0) begin errors++; $display("FAIL mid_dur got %0d want 0", dut.r_dur); end
    btnc = 1'b1;
    repeat (100) @(negedge clk);
    // The enable comes back two clocks after release, so 98 C4 steps.
    checks++; if (dut.r_phase !== 24'(98 * 44)) begin errors++; $display("FAIL restart_phase got %0d want %0d", dut.r_phase, 98 * 44); end
    checks++; if (dut.r_phase !== 24'(phase_of(m_e))) begin errors++; $display("FAIL restart_model got %0d want %0d", dut.r_phase, phase_of(m_e)); end
    checks++; if (dut.r_note !== 3'd0) begin errors++; $display("FAIL restart_note got %0d want 0", dut.r_note); end
  endtask

  initial begin
    btnc = 1'b1;
    sw   = 1'b0;
    test_reset;
    test_muted;
    test_enable_waveform;
    test_sequence;
    test_pause_resume;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
